// File: rtl/ofs_plat_avalon_rdwr_sched_pkg.sv
// Shared types and helpers for the Avalon read/write direction scheduler.
package ofs_plat_avalon_rdwr_sched_pkg;

  typedef enum logic [1:0] {
    S_READ     = 2'd0,
    S_WRITE    = 2'd1,
    S_WR_BURST = 2'd2
  } t_sched_state;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ofs_plat_prim_sat_counter.sv
// Saturating up-counter with synchronous load; load takes priority over increment.
module ofs_plat_prim_sat_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: load, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (inc && (cnt_q < WIDTH'(MAX))) begin
      cnt_d = cnt_q + WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= {WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ofs_plat_avalon_mem_rdwr_sched.sv
// Chooses read or write for the merged Avalon sink each cycle, batching runs of
// the same direction with per-direction limits and never splitting a write burst.
module ofs_plat_avalon_mem_rdwr_sched
  import ofs_plat_avalon_rdwr_sched_pkg::*;
#(
  parameter int MAX_RD_GRANTS = 16,
  parameter int MAX_WR_BURSTS = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rd_valid,
  input  logic wr_valid,
  input  logic wr_eop,
  input  logic sink_waitrequest,
  output logic grant_rd,
  output logic grant_wr,
  output logic dir_write,
  output logic turnaround
);

  localparam int CNT_MAX   = max_int(MAX_RD_GRANTS, MAX_WR_BURSTS);
  localparam int CNT_WIDTH = $clog2(CNT_MAX + 1);

  t_sched_state state_q;
  t_sched_state state_d;
  logic         dir_write_q;
  logic         turnaround_q;

  logic                 gnt_rd;
  logic                 gnt_wr;
  logic                 switch_dir;
  logic                 rd_load;
  logic                 rd_inc;
  logic [CNT_WIDTH-1:0] rd_load_val;
  logic [CNT_WIDTH-1:0] rd_cnt_q;
  logic                 wr_load;
  logic                 wr_inc;
  logic [CNT_WIDTH-1:0] wr_load_val;
  logic [CNT_WIDTH-1:0] wr_cnt_q;
  logic                 rd_below_max;
  logic                 wr_below_max;

  assign rd_below_max = (rd_cnt_q < CNT_WIDTH'(MAX_RD_GRANTS));
  assign wr_below_max = (wr_cnt_q < CNT_WIDTH'(MAX_WR_BURSTS));

  // Grant and next-state decision; reset_n gates grants so nothing issues while in reset.
  always_comb begin
    gnt_rd      = 1'b0;
    gnt_wr      = 1'b0;
    switch_dir  = 1'b0;
    state_d     = state_q;
    rd_load     = 1'b0;
    rd_inc      = 1'b0;
    rd_load_val = {CNT_WIDTH{1'b0}};
    wr_load     = 1'b0;
    wr_inc      = 1'b0;
    wr_load_val = {CNT_WIDTH{1'b0}};
    if (reset_n && !sink_waitrequest) begin
      case (state_q)
        S_READ: begin
          if (rd_valid && (!wr_valid || rd_below_max)) begin
            gnt_rd = 1'b1;
            rd_inc = 1'b1;
          end else if (wr_valid) begin
            gnt_wr      = 1'b1;
            switch_dir  = 1'b1;
            rd_load     = 1'b1;
            wr_load     = 1'b1;
            wr_load_val = wr_eop ? CNT_WIDTH'(1) : {CNT_WIDTH{1'b0}};
            state_d     = wr_eop ? S_WRITE : S_WR_BURST;
          end else begin
            state_d = state_q;
          end
        end
        S_WRITE: begin
          if (wr_valid && (!rd_valid || wr_below_max)) begin
            gnt_wr  = 1'b1;
            wr_inc  = wr_eop;
            state_d = wr_eop ? S_WRITE : S_WR_BURST;
          end else if (rd_valid) begin
            gnt_rd      = 1'b1;
            switch_dir  = 1'b1;
            rd_load     = 1'b1;
            rd_load_val = CNT_WIDTH'(1);
            wr_load     = 1'b1;
            state_d     = S_READ;
          end else begin
            state_d = state_q;
          end
        end
        S_WR_BURST: begin
          // Reads wait until the burst in flight has delivered its last beat.
          if (wr_valid) begin
            gnt_wr  = 1'b1;
            wr_inc  = wr_eop;
            state_d = wr_eop ? S_WRITE : S_WR_BURST;
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = S_READ;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Scheduler state plus registered direction and turnaround outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_READ;
      dir_write_q  <= 1'b0;
      turnaround_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_write_q  <= (state_d != S_READ);
      turnaround_q <= switch_dir;
    end
  end

  ofs_plat_prim_sat_counter #(
    .WIDTH (CNT_WIDTH),
    .MAX   (MAX_RD_GRANTS)
  ) u_rd_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (rd_load),
    .load_val (rd_load_val),
    .inc      (rd_inc),
    .cnt      (rd_cnt_q)
  );

  ofs_plat_prim_sat_counter #(
    .WIDTH (CNT_WIDTH),
    .MAX   (MAX_WR_BURSTS)
  ) u_wr_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (wr_load),
    .load_val (wr_load_val),
    .inc      (wr_inc),
    .cnt      (wr_cnt_q)
  );

  assign grant_rd   = gnt_rd;
  assign grant_wr   = gnt_wr;
  assign dir_write  = dir_write_q;
  assign turnaround = turnaround_q;

endmodule

// File: tb/tb_ofs_plat_avalon_mem_rdwr_sched.sv
// Scoreboard bench: directed cycles push expected {grant_rd,grant_wr,dir_write,turnaround};
// a negedge monitor pops and compares. dut0 uses default limits, dut1 uses limits of 1.
module tb_ofs_plat_avalon_mem_rdwr_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n, rd0, wr0, eop0, wt0;
  logic gr0, gw0, dir0, ta0;
  logic rst1_n, rd1, wr1, eop1, wt1;
  logic gr1, gw1, dir1, ta1;

  ofs_plat_avalon_mem_rdwr_sched #(
    .MAX_RD_GRANTS (16),
    .MAX_WR_BURSTS (4)
  ) dut (
    .clk              (clk),
    .reset_n          (rst0_n),
    .rd_valid         (rd0),
    .wr_valid         (wr0),
    .wr_eop           (eop0),
    .sink_waitrequest (wt0),
    .grant_rd         (gr0),
    .grant_wr         (gw0),
    .dir_write        (dir0),
    .turnaround       (ta0)
  );

  ofs_plat_avalon_mem_rdwr_sched #(
    .MAX_RD_GRANTS (1),
    .MAX_WR_BURSTS (1)
  ) dut1 (
    .clk              (clk),
    .reset_n          (rst1_n),
    .rd_valid         (rd1),
    .wr_valid         (wr1),
    .wr_eop           (eop1),
    .sink_waitrequest (wt1),
    .grant_rd         (gr1),
    .grant_wr         (gw1),
    .dir_write        (dir1),
    .turnaround       (ta1)
  );

  typedef struct packed {
    logic [3:0]  bits;
    logic [15:0] tag;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0;
  exp_t e1;
  int   vectors     = 0;
  int   miscompares = 0;
  int   tag_cnt     = 0;

  function automatic void check(input int d, input exp_t e, input logic [3:0] act);
    vectors++;
    if (act !== e.bits) begin
      miscompares++;
      $display("FAIL dut%0d vec%0d {grant_rd,grant_wr,dir_write,turnaround}: got %b expected %b",
               d, e.tag, act, e.bits);
    end
  endfunction

  // Monitor: one expected entry per pushed cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q0.size() != 0) begin
      e0 = q0.pop_front();
      check(0, e0, {gr0, gw0, dir0, ta0});
    end
    if (q1.size() != 0) begin
      e1 = q1.pop_front();
      check(1, e1, {gr1, gw1, dir1, ta1});
    end
  end

  task automatic step(input logic sel, input logic rst_n, input logic rd, input logic wr,
                      input logic eop, input logic wt, input logic [3:0] exp_bits);
    @(posedge clk);
    #1;
    if (!sel) begin
      rst0_n = rst_n; rd0 = rd; wr0 = wr; eop0 = eop; wt0 = wt;
      q0.push_back('{bits: exp_bits, tag: 16'(tag_cnt)});
    end else begin
      rst1_n = rst_n; rd1 = rd; wr1 = wr; eop1 = eop; wt1 = wt;
      q1.push_back('{bits: exp_bits, tag: 16'(tag_cnt)});
    end
    tag_cnt++;
  endtask

  task automatic run(input logic sel, input int n, input logic rd, input logic wr,
                     input logic eop, input logic wt,
                     input logic [3:0] exp_first, input logic [3:0] exp_rest);
    for (int i = 0; i < n; i++) begin
      step(sel, 1'b1, rd, wr, eop, wt, (i == 0) ? exp_first : exp_rest);
    end
  endtask

  initial begin
    rst0_n = 1'b0; rd0 = 1'b1; wr0 = 1'b1; eop0 = 1'b0; wt0 = 1'b0;
    rst1_n = 1'b0; rd1 = 1'b0; wr1 = 1'b0; eop1 = 1'b0; wt1 = 1'b0;

    // Held in reset with both valid: no grants, registered outputs clear.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);

    // Reads only: grant every cycle, no switch while rd_cnt saturates.
    run(1'b0, 40, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b1000);

    // Both valid, single-beat writes: 4 writes then 16 reads, repeating.
    for (int rep = 0; rep < 2; rep++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0100);
      run(1'b0, 3, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0111, 4'b0110);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1010);
      run(1'b0, 15, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1001, 4'b1000);
    end

    // 4-beat burst with a 3-cycle gap after beat 2: reads stay blocked.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0111);
    run(1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0010);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0110);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0110);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010);

    // Stall at rd_cnt=7 for 5 cycles, then 9 more reads before the write switch.
    run(1'b0, 6, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1001, 4'b1000);
    run(1'b0, 5, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000);
    run(1'b0, 9, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1000, 4'b1000);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0111);

    // Asynchronous reset mid-burst, then fresh S_READ with rd_cnt=0, then idle hold.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1000);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

    // Limits of 1 with 2-beat writes: R, W, W, R, W, W ...
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1000);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0111);
    for (int rep = 0; rep < 3; rep++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1010);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0101);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0111);
    end

    for (int i = 0; i < 10 && (q0.size() != 0 || q1.size() != 0); i++) begin
      @(posedge clk);
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", q0.size() + q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
